rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Round-robin arbiter sharing one 8-way active-low select resource among eight requesters. Grants one requester at a time, holds the grant while its request stays high, and inserts a one-cycle dead gap between grants. Drives the 3-bit select code plus a polarity-selectable one-hot grant vector with the same encoding as the team's 3-to-8 decoder. Sits between requesting blocks and the shared select/enable lines.

## Interface
- HOLD_MAX, 16, maximum consecutive grant cycles per requester when the timeout is compiled in; legal range 1..2^CNT_W-1.
- CNT_W, 8, width of the hold counter.

- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_req  input  8  level request per requester; bit n is requester n.
- i_opt  input  1  output polarity: 0 = active-low grant vector, 1 = inverted (active-high).
- o_sel  output 3  index of the current or most recent grantee.
- o_valid output 1  high while a grant is active.
- o_y    output 8  one-hot grant vector; internal pattern r_y is inverted when i_opt=1.

## Operation
- States: IDLE, GRANT, GAP.
- Internal r_y: 8'hFF when no grant; when granted, bit o_sel is 0 and all other bits are 1.
- o_y = i_opt ? ~r_y : r_y. This path is combinational from i_opt; all other outputs are registered.
- Pointer last: index of the last grantee. The search order is last+1, last+2, … wrapping modulo 8. The first set i_req bit in that order wins.
- IDLE: if any i_req bit is set, grant the winner: o_sel=winner, last=winner, counter=0, state=GRANT. Otherwise stay in IDLE.
- GRANT: the counter increments every cycle, saturating at HOLD_MAX. Release the grant if i_req[o_sel]=0, or if the timeout is enabled and counter=HOLD_MAX-1. On release: state=GAP, o_valid=0, r_y=8'hFF. o_sel keeps its value.
- GAP: lasts exactly one cycle and never drives a grant. At its closing edge, arbitrate as in IDLE: go to GRANT if any request is set, otherwise go to IDLE.
- A released requester has the lowest priority in the next search, because the search starts at last+1.
- If the grantee is the only requester, it is re-granted after the gap.
- Requests arriving or dropping for non-granted bits have no effect during GRANT.

## Timing
- Reset, at the next edge: state=IDLE, o_valid=0, o_sel=0, r_y=8'hFF, last=7 (so the first search starts at 0), counter=0. o_y reads 8'hFF when i_opt=0 and 8'h00 when i_opt=1.
- Reset mid-grant: the grant is dropped at that edge; no gap cycle follows.
- Grant latency: request sampled at edge k → o_valid, o_sel and o_y valid after edge k, i.e. one cycle.
- Release latency: i_req[o_sel] low at edge k → o_valid low after edge k.
- Grant-to-grant spacing: exactly one cycle with o_valid=0.
- Timeout: the grant lasts exactly HOLD_MAX cycles with o_valid=1. HOLD_MAX=1 gives single-cycle grants.
- If the request drop and the timeout occur at the same edge, the result is a single release; they are indistinguishable.
- o_y follows i_opt within the same cycle, with no registering.

## Configuration
- ARB_TIMEOUT_EN defined: the hold counter and forced release at HOLD_MAX are compiled in.
- ARB_TIMEOUT_EN undefined: the counter logic is removed, HOLD_MAX is ignored, and the grant is held until i_req[o_sel] drops.
- All other behaviour is identical in both builds.

## Structure
- Package arb8_pkg holds:
  - the state enum {IDLE, GRANT, GAP}
  - N_REQ=8 and SEL_W=3
  - the idle pattern 8'hFF
- Sub-module rr_pick8 is combinational. Inputs: 8-bit request and 3-bit pointer. Outputs: 3-bit winner and any-request flag. It implements the rotated priority search.
- The top level holds the FSM, the pointer, the counter, the r_y register and the polarity mux.

## Test plan
- Reset with i_opt=0, i_req=0 → o_y=8'hFF, o_valid=0, o_sel=0. Set i_opt=1 → o_y=8'h00 in the same cycle.
- i_req=8'h81 from reset → requester 0 granted first (o_y=8'hFE). Drop bit 0 → one gap cycle, then o_sel=7, o_y=8'h7F.
- i_req=8'hFF held, timeout build, HOLD_MAX=4 → grants 0,1,2,…,7,0 in order. Each grant lasts 4 cycles with a 1-cycle gap between grants.
- Same stimulus without ARB_TIMEOUT_EN → requester 0 is held indefinitely. Clearing bit 0 moves the grant to requester 1 after one gap cycle.
- Single requester i_req=8'h20, timeout build → repeated grants to o_sel=5, pattern 4 cycles on / 1 cycle off.
- Assert i_rst during a grant to requester 3 → o_valid=0 and o_y=8'hFF after that edge. Next grant with i_req=8'h08 → o_sel=3, because the pointer was reset to 7.

Source files
------------

// File: rtl/arb8_pkg.sv
// Shared types and constants for the 8-way round-robin select arbiter.
package arb8_pkg;

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   localparam int N_REQ = 8;
   localparam int SEL_W = 3;
   localparam logic [N_REQ-1:0] IDLE_PAT = 8'hFF;

   // Active-low one-hot pattern for a select code, same encoding as the 3-to-8 decoder.
   function automatic logic [N_REQ-1:0] grant_pattern(input logic [SEL_W-1:0] sel);
      grant_pattern = ~(N_REQ'(1) << sel);
   endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotated-priority search: first set request after the pointer, wrapping modulo 8.
module rr_pick8
   import arb8_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] winner,
   output logic             any
);

   logic [SEL_W-1:0] idx;

   // Offset 8 wraps back to ptr itself, so a lone previous grantee still wins.
   always_comb begin
      winner = '0;
      any    = 1'b0;
      idx    = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = ptr + SEL_W'(i);
         if (!any && req[idx]) begin
            winner = idx;
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for one shared active-low 8-way select with a dead cycle between grants.
// Optional hold timeout is compiled in with `define ARB_TIMEOUT_EN.
module rr_arbiter8
   import arb8_pkg::*;
#(
   parameter int HOLD_MAX = 16,
   parameter int CNT_W    = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [N_REQ-1:0] i_req,
   input  logic             i_opt,
   output logic [SEL_W-1:0] o_sel,
   output logic             o_valid,
   output logic [N_REQ-1:0] o_y
);

   state_t           state;
   logic [SEL_W-1:0] last;
   logic [SEL_W-1:0] win;
   logic             any;
   logic             release_now;
   logic [N_REQ-1:0] r_y;

   // Out-of-range HOLD_MAX leaves this marker scope in the elaborated hierarchy.
   if (HOLD_MAX < 1 || HOLD_MAX > (1 << CNT_W) - 1) begin : g_hold_max_out_of_range
   end

   rr_pick8 u_pick (
      .req    (i_req),
      .ptr    (last),
      .winner (win),
      .any    (any)
   );

`ifdef ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
   localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_MAX);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt <= '0;
      end else if (state == GRANT) begin
         if (cnt != HOLD_SAT) cnt <= cnt + 1'b1;
      end else begin
         cnt <= '0;
      end
   end

   assign release_now = !i_req[o_sel] || (cnt == HOLD_LAST);
`else
   assign release_now = !i_req[o_sel];
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         o_valid <= 1'b0;
         o_sel   <= '0;
         r_y     <= IDLE_PAT;
         last    <= SEL_W'(N_REQ - 1);
      end else begin
         case (state)
            IDLE, GAP: begin
               if (any) begin
                  state   <= GRANT;
                  o_valid <= 1'b1;
                  o_sel   <= win;
                  last    <= win;
                  r_y     <= grant_pattern(win);
               end else begin
                  state   <= IDLE;
                  o_valid <= 1'b0;
                  r_y     <= IDLE_PAT;
               end
            end
            GRANT: begin
               // o_sel is left alone on release; it reports the most recent grantee.
               if (release_now) begin
                  state   <= GAP;
                  o_valid <= 1'b0;
                  r_y     <= IDLE_PAT;
               end
            end
            default: begin
               state   <= IDLE;
               o_valid <= 1'b0;
               r_y     <= IDLE_PAT;
            end
         endcase
      end
   end

   assign o_y = i_opt ? ~r_y : r_y;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Randomized + directed bench for rr_arbiter8: cycle-level reference model feeding a scoreboard queue.
module tb_rr_arbiter8;

   localparam int HOLD = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       opt;
   logic [2:0] o_sel;
   logic       o_valid;
   logic [7:0] o_y;

   int tests = 0;
   int fails = 0;
   int cycle = 0;

   logic [11:0] exp_q[$];

   // Reference model state: who owns the resource (-1 = nobody), last grantee, cycles held.
   int         owner;
   int         last_g;
   int         held;
   logic [2:0] msel;

   rr_arbiter8 #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_req   (req),
      .i_opt   (opt),
      .o_sel   (o_sel),
      .o_valid (o_valid),
      .o_y     (o_y)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycle <= cycle + 1;

   // ---------------- reference model ----------------
   task automatic model_step();
      if (rst) begin
         owner  = -1;
         last_g = 7;
         msel   = 3'd0;
         held   = 0;
      end else if (owner >= 0) begin
         if (!req[owner] || (TO_EN && held >= HOLD)) owner = -1;
         else held++;
      end else begin
         for (int d = 1; d <= 8; d++) begin
            int c;
            c = (last_g + d) % 8;
            if (req[c]) begin
               owner  = c;
               last_g = c;
               msel   = 3'(c);
               held   = 1;
               break;
            end
         end
      end
   endtask

   task automatic push_exp();
      logic [7:0] y;
      y = 8'hFF;
      if (owner >= 0) y[owner] = 1'b0;
      if (opt) y = ~y;
      exp_q.push_back({(owner >= 0), msel, y});
   endtask

   // ---------------- driver ----------------
   // One call = one clock edge; the given values are applied just after it for the next edge.
   task automatic cyc(input logic r, input logic [7:0] q, input logic o);
      @(posedge clk);
      model_step();
      #1;
      rst = r;
      req = q;
      opt = o;
      push_exp();
   endtask

   task automatic spot(input string name, input logic [7:0] act, input logic [7:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, want);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   initial begin
      logic [11:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (o_valid !== e[11]) begin
               fails++;
               $display("FAIL sb_valid at cycle %0d: got %b, expected %b", cycle, o_valid, e[11]);
            end
            tests++;
            if (o_sel !== e[10:8]) begin
               fails++;
               $display("FAIL sb_sel at cycle %0d: got %0d, expected %0d", cycle, o_sel, e[10:8]);
            end
            tests++;
            if (o_y !== e[7:0]) begin
               fails++;
               $display("FAIL sb_y at cycle %0d: got %h, expected %h", cycle, o_y, e[7:0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] rq;
      rst = 1'b1;
      req = 8'h00;
      opt = 1'b0;

      // Reset state and combinational polarity path
      cyc(1, 8'h00, 0);
      cyc(0, 8'h00, 0);
      #1;
      spot("rst_y", o_y, 8'hFF);
      spot("rst_valid", {7'd0, o_valid}, 8'h00);
      spot("rst_sel", {5'd0, o_sel}, 8'h00);
      cyc(0, 8'h00, 1);
      #1;
      spot("opt_y", o_y, 8'h00);

      // 8'h81 from reset: 0 first, then 7 after one gap cycle
      cyc(0, 8'h81, 0);
      cyc(0, 8'h81, 0);
      #1;
      spot("g0_sel", {5'd0, o_sel}, 8'h00);
      spot("g0_y", o_y, 8'hFE);
      cyc(0, 8'h80, 0);
      cyc(0, 8'h80, 0);
      #1;
      spot("gap_valid", {7'd0, o_valid}, 8'h00);
      cyc(0, 8'h80, 0);
      #1;
      spot("g7_sel", {5'd0, o_sel}, 8'h07);
      spot("g7_y", o_y, 8'h7F);
      repeat (3) cyc(0, 8'h00, 0);

      // All requesting: timeout rotation, or a held grant without the timeout
      repeat (46) cyc(0, 8'hFF, 0);
      repeat (8) cyc(0, 8'hFE, 1);
      repeat (3) cyc(0, 8'h00, 0);

      // Lone requester 5: re-granted after each gap
      repeat (14) cyc(0, 8'h20, 0);
      repeat (2) cyc(0, 8'h00, 0);

      // Reset during a grant to requester 3
      cyc(0, 8'h08, 0);
      cyc(0, 8'h08, 0);
      cyc(1, 8'h08, 0);
      cyc(0, 8'h08, 0);
      #1;
      spot("rstgrant_valid", {7'd0, o_valid}, 8'h00);
      spot("rstgrant_y", o_y, 8'hFF);
      cyc(0, 8'h08, 0);
      #1;
      spot("regrant_sel", {5'd0, o_sel}, 8'h03);
      repeat (3) cyc(0, 8'h00, 0);

      // Randomized: slowly toggling requests, random polarity, rare resets
      rq = 8'h00;
      for (int n = 0; n < 600; n++) begin
         for (int b = 0; b < 8; b++)
            if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
         cyc(($urandom_range(0, 99) == 0), rq, 1'($urandom_range(0, 1)));
      end

      // Let the monitor drain the last expectations, bounded
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
